crc_decode_ctrl: RTL and testbench



---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_err_counter.sv | 21 ++
 rtl/crc_decode_ctrl.sv | 95 +++++++++
 tb/tb_crc_decode_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC-4 (x^4+x+1) decode controller.
package crc_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;
    localparam int CRC_W  = 4;
    localparam int CNT_W  = 4;

    // x^4 + x + 1 without the implicit leading term
    localparam logic [CRC_W-1:0] POLY = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/crc_err_counter.sv
// Saturating event counter; used for the CRC error tally.
module crc_err_counter
    import crc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/crc_decode_ctrl.sv
// Sequencer for the bit-serial CRC-4 decoder: load, shift, result handshake.
// Optional saturating error counter enabled by CRC_CTRL_ERR_CNT_EN.
module crc_decode_ctrl
    import crc_pkg::*;
#(
    parameter int CODE_W = crc_pkg::CODE_W,
    parameter int DATA_W = crc_pkg::DATA_W,
    parameter int CNT_W  = crc_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              dec_load,
    output logic              dec_shift_en,
    output logic              dec_processing_complete,
    output logic [CODE_W-1:0] dec_encoded_data,
    input  logic [DATA_W-1:0] dec_decoded_data,
    input  logic              dec_error_detected,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_error,
    output logic              busy,
    output logic [15:0]       err_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CODE_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] code_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            code_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_reg <= in_code;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    // exit compare wins so cnt never wraps
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready                = (state == IDLE);
    assign dec_load                = (state == LOAD);
    assign dec_shift_en            = (state == SHIFT);
    assign dec_processing_complete = (state == DONE);
    assign out_valid               = (state == DONE);
    assign busy                    = (state != IDLE);
    assign dec_encoded_data        = code_reg;

    // decoder holds its result steady while no load/shift is issued
    assign out_data  = dec_decoded_data;
    assign out_error = dec_error_detected;

`ifdef CRC_CTRL_ERR_CNT_EN
    crc_err_counter #(
        .W(16)
    ) u_err_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid && out_ready && out_error),
        .count(err_count)
    );
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_crc_decode_ctrl.sv
// Directed bench for crc_decode_ctrl with a behavioural serial CRC-4 decoder.
module tb_crc_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_code;
    logic        dec_load;
    logic        dec_shift_en;
    logic        dec_processing_complete;
    logic [11:0] dec_encoded_data;
    logic [7:0]  dec_decoded_data;
    logic        dec_error_detected;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_error;
    logic        busy;
    logic [15:0] err_count;

    int n_total;
    int n_pass;
    logic [15:0] exp_cnt;

    crc_decode_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_code                (in_code),
        .dec_load               (dec_load),
        .dec_shift_en           (dec_shift_en),
        .dec_processing_complete(dec_processing_complete),
        .dec_encoded_data       (dec_encoded_data),
        .dec_decoded_data       (dec_decoded_data),
        .dec_error_detected     (dec_error_detected),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_data               (out_data),
        .out_error              (out_error),
        .busy                   (busy),
        .err_count              (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // serial decoder: long division of the codeword by x^4+x+1, MSB first
    logic [11:0] m_sr;
    logic [11:0] m_seen;
    logic [3:0]  m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sr   <= '0;
            m_seen <= '0;
            m_rem  <= '0;
        end else if (dec_load) begin
            m_sr   <= dec_encoded_data;
            m_seen <= '0;
            m_rem  <= '0;
        end else if (dec_shift_en) begin
            m_sr   <= {m_sr[10:0], 1'b0};
            m_seen <= {m_seen[10:0], m_sr[11]};
            m_rem  <= {m_rem[2:0], m_sr[11]} ^ (m_rem[3] ? 4'b0011 : 4'b0000);
        end
    end

    assign dec_decoded_data   = m_seen[11:4];
    assign dec_error_detected = |m_rem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_word(input logic [11:0] code, input logic [7:0] data,
                            input logic err, input int hold,
                            input bit queue_next, input logic [11:0] next_code);
        logic [14:0] lm, sm, vm, rm, bm;
        logic [7:0]  d0;
        bit          stable;
        int          w;
        lm = '0; sm = '0; vm = '0; rm = '0; bm = '0;
        if (!(in_valid && in_code == code)) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_code  = code;
        end
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_timeout", 32'(w < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i > 1) @(negedge clk);
            if (queue_next && i == 3) begin
                in_valid = 1'b1;
                in_code  = next_code;
            end
            lm[i] = dec_load;
            sm[i] = dec_shift_en;
            vm[i] = out_valid;
            rm[i] = in_ready;
            bm[i] = busy;
            if (i == 1) chk("enc_data", 32'(dec_encoded_data), 32'(code));
        end
        chk("load_timing", 32'(lm), 32'h0002);
        chk("shift_timing", 32'(sm), 32'h3FFC);
        chk("valid_timing", 32'(vm), 32'h4000);
        chk("in_ready_busy", 32'(rm), 32'h0000);
        chk("busy_mask", 32'(bm), 32'h7FFE);
        chk("out_data", 32'(out_data), 32'(data));
        chk("out_error", 32'(out_error), 32'(err));
        chk("proc_complete", 32'(dec_processing_complete), 32'd1);
        chk("code_kept", 32'(dec_encoded_data), 32'(code));
        d0 = out_data;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!out_valid || out_data != d0 || !dec_processing_complete || in_ready)
                stable = 1'b0;
        end
        if (hold > 0) chk("backpressure_hold", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
`ifdef CRC_CTRL_ERR_CNT_EN
        if (err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("err_count", 32'(err_count), 32'(exp_cnt));
    endtask

    typedef struct {
        logic [11:0] code;
        logic [7:0]  data;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit seen_valid;
        vecs[0] = '{code: 12'hA5B, data: 8'hA5, err: 1'b0, hold: 0};
        vecs[1] = '{code: 12'hA5A, data: 8'hA5, err: 1'b1, hold: 0};
        vecs[2] = '{code: 12'h013, data: 8'h01, err: 1'b0, hold: 0};
        vecs[3] = '{code: 12'hFF4, data: 8'hFF, err: 1'b0, hold: 5};
        vecs[4] = '{code: 12'hFF5, data: 8'hFF, err: 1'b1, hold: 2};
        vecs[5] = '{code: 12'h000, data: 8'h00, err: 1'b0, hold: 0};

        n_total   = 0;
        n_pass    = 0;
        exp_cnt   = 16'h0000;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({dec_load, dec_shift_en, dec_processing_complete, out_valid}), 32'd0);
        chk("rst_code", 32'(dec_encoded_data), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_word(vecs[v].code, vecs[v].data, vecs[v].err, vecs[v].hold, 1'b0, 12'h000);
        end

        // word held on the input while the previous word is still shifting
        run_word(12'hA5B, 8'hA5, 1'b0, 0, 1'b1, 12'h000);
        run_word(12'h000, 8'h00, 1'b0, 0, 1'b0, 12'h000);

        // asynchronous reset in the middle of SHIFT (cnt == 5)
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 12'hA5A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_shift_active", 32'(dec_shift_en), 32'd1);
        rst = 1'b1;
        #1;
        exp_cnt = 16'h0000;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_strobes", 32'({dec_load, dec_shift_en, dec_processing_complete, out_valid}), 32'd0);
        chk("arst_code", 32'(dec_encoded_data), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) seen_valid = 1'b1;
        end
        chk("no_partial_result", 32'(seen_valid), 32'd0);
        run_word(12'hA5B, 8'hA5, 1'b0, 0, 1'b0, 12'h000);
        run_word(12'hA5A, 8'hA5, 1'b1, 0, 1'b0, 12'h000);

`ifdef CRC_CTRL_ERR_CNT_EN
        @(negedge clk);
        force dut.u_err_counter.count = 16'hFFFE;
        @(negedge clk);
        release dut.u_err_counter.count;
        exp_cnt = 16'hFFFE;
        for (int s = 0; s < 3; s++) begin
            run_word(12'hA5A, 8'hA5, 1'b1, 0, 1'b0, 12'h000);
        end
        chk("saturated", 32'(err_count), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
